rr_data_write_arbiter: RTL
==========================

Name: rr_data_write_arbiter

Overview:
- N-input arbiter for data-array write requests (data, set, blockSelOH, way, mask) feeding a single cache data-array write port.
- Selectable fixed-priority or round-robin policy.
- One-entry registered output stage breaks the ready/valid timing path between requesters and the data array.
- Succeeds the 2-input combinational priority arbiter; adds parametrised channel count, fairness and buffering.

Parameters:
N_IN, 4, number of requesters (>=2)
DATA_W, 32, write data width
SET_W, 6, set index width
BLK_W, 2, blockSelOH width (one-hot block select)
WAY_W, 4, way one-hot width
MASK_W, 4, byte mask width (DATA_W/8)
RR_EN, 1, 1 = round-robin, 0 = fixed priority (lowest index wins)
CH_W, clog2(N_IN), chosen-index width (derived)

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-low reset
io_in_valid  in  N_IN  request valid per channel
io_in_ready  out  N_IN  request accepted per channel
io_in_bits_data  in  N_IN*DATA_W  per-channel data; channel i at [i*DATA_W +: DATA_W]
io_in_bits_set  in  N_IN*SET_W  per-channel set
io_in_bits_blockSelOH  in  N_IN*BLK_W  per-channel block select
io_in_bits_way  in  N_IN*WAY_W  per-channel way
io_in_bits_mask  in  N_IN*MASK_W  per-channel mask
io_out_ready  in  1  data array accepts
io_out_valid  out  1  registered request valid
io_out_bits_data/set/blockSelOH/way/mask  out  DATA_W/SET_W/BLK_W/WAY_W/MASK_W  registered request fields
io_out_chosen  out  CH_W  index of the channel that produced the current output

Behaviour:
- Reset (reset==0 at a clock edge): out_valid=0, all out bits=0, chosen=0, rr pointer last=N_IN-1 (channel 0 has first priority). Reset overrides everything, including a stalled output (its entry is dropped).
- Accept condition: acc = !out_valid || io_out_ready (full-throughput pipe register).
- Grant (combinational, one-hot g over io_in_valid):
  - RR_EN=0: lowest valid index.
  - RR_EN=1: first valid index scanning last+1, last+2, ... with wrap modulo N_IN.
  - No valid input: g=0.
- io_in_ready[i] = acc && g[i]. At most one ready high per cycle; ready never high for an invalid channel.
- Fire on input i (valid && ready) loads that channel's fields into the output register, sets out_valid=1, chosen=i, and (RR_EN=1) sets last=i.
- No fire: pointer unchanged.
- io_out_ready=1 with no fire: out_valid clears next cycle.
- Stall: while out_valid && !io_out_ready, output bits and chosen hold stable; all io_in_ready=0; pointer frozen.
- Latency: input fire at cycle t -> io_out_valid at t+1. Throughput: 1 request/cycle when io_out_ready stays high.
- Bits are passed through unmodified; no validation of one-hot fields.
- Fairness (RR_EN=1): with all channels continuously valid and no stall, each channel is granted exactly once every N_IN fires.
- Inputs may drop valid without handshake; the arbiter re-evaluates every cycle (no grant lock).

Test Plan:
- Reset: hold reset=0 three cycles with all inputs valid -> io_out_valid=0, io_in_ready=0000, chosen=0, bits=0. Release -> first fire grants ch0; io_out_valid=1 next cycle.
- Fixed priority (RR_EN=0), N_IN=4, valid=1110 (ch0 idle), io_out_ready=1, ch1 data=0x11111111 -> io_in_ready=0010; next cycle out data=0x11111111, chosen=1. Repeat 5 cycles -> chosen stays 1.
- Round-robin (RR_EN=1), valid=1111 constant, io_out_ready=1 -> chosen sequence 0,1,2,3,0,1 on consecutive cycles. Deassert ch2 after the ch1 grant -> next chosen=3.
- Backpressure: valid=1111, fire ch0 (set=0x05, way=0001, mask=1111), then io_out_ready=0 for 4 cycles -> outputs hold set=0x05/chosen=0, io_in_ready=0000. Raise ready -> next chosen=1 (pointer did not advance during the stall).
- Wrap and sparse: last=3 via single ch3 request, then valid=1001 -> ch0 granted. Then valid=1000 only -> ch3 granted again (no starvation when alone).
- Reset mid-stall: out_valid=1, io_out_ready=0, assert reset one cycle -> out_valid=0 and last=N_IN-1 next cycle. With valid=1111 after release -> chosen=0.

Source files
------------

// File: rtl/rr_data_write_arbiter.sv
// N-input write-request arbiter for a cache data-array port with selectable fixed-priority or
// round-robin policy and a one-entry registered output stage.
module rr_data_write_arbiter #(
   parameter  int N_IN   = 4,
   parameter  int DATA_W = 32,
   parameter  int SET_W  = 6,
   parameter  int BLK_W  = 2,
   parameter  int WAY_W  = 4,
   parameter  int MASK_W = 4,
   parameter  int RR_EN  = 1,
   localparam int CH_W   = (N_IN > 1) ? $clog2(N_IN) : 1
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [N_IN-1:0]          io_in_valid,
   output logic [N_IN-1:0]          io_in_ready,
   input  logic [N_IN*DATA_W-1:0]   io_in_bits_data,
   input  logic [N_IN*SET_W-1:0]    io_in_bits_set,
   input  logic [N_IN*BLK_W-1:0]    io_in_bits_blockSelOH,
   input  logic [N_IN*WAY_W-1:0]    io_in_bits_way,
   input  logic [N_IN*MASK_W-1:0]   io_in_bits_mask,
   input  logic                     io_out_ready,
   output logic                     io_out_valid,
   output logic [DATA_W-1:0]        io_out_bits_data,
   output logic [SET_W-1:0]         io_out_bits_set,
   output logic [BLK_W-1:0]         io_out_bits_blockSelOH,
   output logic [WAY_W-1:0]         io_out_bits_way,
   output logic [MASK_W-1:0]        io_out_bits_mask,
   output logic [CH_W-1:0]          io_out_chosen
);

   logic [CH_W-1:0]   last;
   logic [CH_W-1:0]   cand_idx;
   logic [CH_W-1:0]   grant_idx;
   logic [N_IN-1:0]   grant;
   logic              found;
   logic              acc;
   logic              fire;
   logic [DATA_W-1:0] sel_data;
   logic [SET_W-1:0]  sel_set;
   logic [BLK_W-1:0]  sel_blk;
   logic [WAY_W-1:0]  sel_way;
   logic [MASK_W-1:0] sel_mask;

   // Scan order starts just past the last winner (round-robin) or at channel 0 (fixed).
   always_comb begin
      // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      cand_idx  = '0;
      for (int k = 1; k <= N_IN; k++) begin
         cand_idx = (RR_EN != 0) ? CH_W'((int'(last) + k) % N_IN) : CH_W'(k - 1);
         if (!found && io_in_valid[cand_idx]) begin
            found           = 1'b1;
            grant[cand_idx] = 1'b1;
            grant_idx       = cand_idx;
         end
      end
   end

   always_comb begin
      sel_data = '0;
      sel_set  = '0;
      sel_blk  = '0;
      sel_way  = '0;
      sel_mask = '0;
      for (int i = 0; i < N_IN; i++) begin
         if (grant[i]) begin
            sel_data = io_in_bits_data[i*DATA_W +: DATA_W];
            sel_set  = io_in_bits_set[i*SET_W +: SET_W];
            sel_blk  = io_in_bits_blockSelOH[i*BLK_W +: BLK_W];
            sel_way  = io_in_bits_way[i*WAY_W +: WAY_W];
            sel_mask = io_in_bits_mask[i*MASK_W +: MASK_W];
         end
      end
   end

   // The register can take a new entry when empty or when it drains this cycle.
   assign acc         = !io_out_valid || io_out_ready;
   assign fire        = reset && acc && found;
   assign io_in_ready = fire ? grant : '0;

   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!reset) begin
         io_out_valid           <= 1'b0;
         io_out_bits_data       <= '0;
         io_out_bits_set        <= '0;
         io_out_bits_blockSelOH <= '0;
         io_out_bits_way        <= '0;
         io_out_bits_mask       <= '0;
         io_out_chosen          <= '0;
         last                   <= CH_W'(N_IN - 1);
      end else if (fire) begin
         io_out_valid           <= 1'b1;
         io_out_bits_data       <= sel_data;
         io_out_bits_set        <= sel_set;
         io_out_bits_blockSelOH <= sel_blk;
         io_out_bits_way        <= sel_way;
         io_out_bits_mask       <= sel_mask;
         io_out_chosen          <= grant_idx;
         if (RR_EN != 0) last <= grant_idx;
      end else if (io_out_ready) begin
         io_out_valid <= 1'b0;
      end
   end

endmodule
